// File: rtl/smaesh_arbiter_v2_pkg.sv
// Shared types for the SMAesH stream arbiter: FSM states and counter sizing.
package smaesh_arbiter_pkg;

  typedef enum logic [2:0] {
    UNSEEDED,
    RESEEDING,
    NOKEY,
    READY,
    KEY_FETCH,
    KEY_LAST
  } state_e;

  // Width of the saturating block counter; a disabled period still needs one bit.
  function automatic int cnt_width(input int period);
    return (period == 0) ? 1 : $clog2(period + 1);
  endfunction

endpackage

// File: rtl/smaesh_arbiter_v2_if.sv
// Stream, PRNG, KSU and AES handshake bundle around the arbiter.
interface smaesh_arbiter_v2_if #(parameter int TAG_W = 8);
  logic             in_seed_valid, in_seed_ready;
  logic             in_key_valid, in_key_ready;
  logic             in_data_valid, in_data_ready;
  logic [TAG_W-1:0] in_data_tag;
  logic             prng_busy, prng_seeded, prng_start_reseed;
  logic             KSU_in_ready, KSU_busy, KSU_last_key_computation_required;
  logic             KSU_valid_in, KSU_start_fetch_procedure;
  logic             aes_in_ready, aes_busy, aes_valid_in;
  logic             out_valid, out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             reseed_required;

  modport master (
    input  in_seed_valid, in_key_valid, in_data_valid, in_data_tag,
    input  prng_busy, prng_seeded,
    input  KSU_in_ready, KSU_busy, KSU_last_key_computation_required,
    input  aes_in_ready, aes_busy, out_valid, out_ready,
    output in_seed_ready, in_key_ready, in_data_ready, prng_start_reseed,
    output KSU_valid_in, KSU_start_fetch_procedure, aes_valid_in,
    output out_tag, reseed_required
  );

  modport slave (
    output in_seed_valid, in_key_valid, in_data_valid, in_data_tag,
    output prng_busy, prng_seeded,
    output KSU_in_ready, KSU_busy, KSU_last_key_computation_required,
    output aes_in_ready, aes_busy, out_valid, out_ready,
    input  in_seed_ready, in_key_ready, in_data_ready, prng_start_reseed,
    input  KSU_valid_in, KSU_start_fetch_procedure, aes_valid_in,
    input  out_tag, reseed_required
  );
endinterface

// File: rtl/smaesh_arbiter_v2_tag_fifo.sv
// In-order tag FIFO; wrap-bit pointers distinguish full from empty.
module smaesh_tag_fifo #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [TAG_W-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [TAG_W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [TAG_W-1:0] mem_q [DEPTH];
  logic             do_pop, do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot, so a push into a full FIFO is fine that cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/smaesh_arbiter_v2.sv
// Seed/key/data stream arbiter with forced reseeding and an output tag FIFO.
module smaesh_arbiter_v2
  import smaesh_arbiter_pkg::*;
#(
  parameter int RESEED_PERIOD = 1024,
  parameter int TAG_W         = 8,
  parameter int DEPTH         = 4
) (
  input logic                 clk,
  input logic                 rst,
  smaesh_arbiter_v2_if.master bus
);
  localparam int            CW      = cnt_width(RESEED_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = (RESEED_PERIOD == 0) ? CW'(1) : CW'(RESEED_PERIOD);

  state_e           state_q, state_d;
  logic             key_loaded_q, key_loaded_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_sent_q, last_sent_d;
  logic             ksu_busy_q, aes_busy_q;
  logic             fifo_full, fifo_empty, push, pop, idle, reseed_req, data_ok;
  logic             seed_rdy, key_rdy, data_rdy, aes_v, ksu_v, reseed_p, fetch_p;
  logic [TAG_W-1:0] head;

  assign idle       = ~bus.aes_busy & ~bus.KSU_busy & fifo_empty;
  assign reseed_req = (RESEED_PERIOD != 0) && (cnt_q == CNT_MAX);
  assign pop        = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    key_loaded_d = key_loaded_q;
    cnt_d        = cnt_q;
    last_sent_d  = last_sent_q;
    seed_rdy = 1'b0; key_rdy = 1'b0; data_rdy = 1'b0; aes_v = 1'b0;
    ksu_v    = 1'b0; reseed_p = 1'b0; fetch_p = 1'b0; push = 1'b0; data_ok = 1'b0;
    case (state_q)
      UNSEEDED, NOKEY, READY: begin
        // Reseeding with blocks in flight is only blocked once a key is in use.
        seed_rdy = ~bus.prng_busy & ((state_q != READY) | idle);
        if (bus.in_seed_valid & seed_rdy) begin
          reseed_p = 1'b1;
          cnt_d    = '0;
          state_d  = RESEEDING;
        end else if (state_q != UNSEEDED && bus.in_key_valid && !bus.in_seed_valid && idle) begin
          fetch_p      = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = KEY_FETCH;
        end else if (state_q == READY) begin
          data_ok  = key_loaded_q & ~fifo_full & ~reseed_req & ~bus.in_seed_valid & ~bus.in_key_valid;
          aes_v    = bus.in_data_valid & data_ok;
          data_rdy = bus.aes_in_ready & data_ok;
          if (bus.in_data_valid & data_rdy) begin
            push = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESEEDING: begin
        if (bus.prng_seeded & ~bus.prng_busy) state_d = key_loaded_q ? READY : NOKEY;
      end
      KEY_FETCH: begin
        ksu_v   = bus.in_key_valid;
        key_rdy = bus.KSU_in_ready;
        if (ksu_busy_q & ~bus.KSU_busy) begin
          if (bus.KSU_last_key_computation_required) begin
            last_sent_d = 1'b0;
            state_d     = KEY_LAST;
          end else begin
            key_loaded_d = 1'b1;
            state_d      = READY;
          end
        end
      end
      KEY_LAST: begin
        // One dummy encryption derives the last-round key; no tag is owed for it.
        aes_v = ~last_sent_q;
        if (~last_sent_q & bus.aes_in_ready) last_sent_d = 1'b1;
        if (last_sent_q & aes_busy_q & ~bus.aes_busy) begin
          key_loaded_d = 1'b1;
          state_d      = READY;
        end
      end
      default: state_d = UNSEEDED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNSEEDED;
      key_loaded_q <= 1'b0;
      cnt_q        <= '0;
      last_sent_q  <= 1'b0;
      ksu_busy_q   <= 1'b0;
      aes_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_loaded_q <= key_loaded_d;
      cnt_q        <= cnt_d;
      last_sent_q  <= last_sent_d;
      ksu_busy_q   <= bus.KSU_busy;
      aes_busy_q   <= bus.aes_busy;
    end
  end

  smaesh_tag_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (bus.in_data_tag),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  // Outputs are combinational, so they are forced low while reset is held.
  assign bus.in_seed_ready             = seed_rdy & ~rst;
  assign bus.in_key_ready              = key_rdy & ~rst;
  assign bus.in_data_ready             = data_rdy & ~rst;
  assign bus.aes_valid_in              = aes_v & ~rst;
  assign bus.KSU_valid_in              = ksu_v & ~rst;
  assign bus.prng_start_reseed         = reseed_p & ~rst;
  assign bus.KSU_start_fetch_procedure = fetch_p & ~rst;
  assign bus.reseed_required           = reseed_req & ~rst;
  assign bus.out_tag                   = (fifo_empty | rst) ? '0 : head;
endmodule

// File: tb/tb_smaesh_arbiter_v2.sv
// Bench for smaesh_arbiter_v2: one instance with RESEED_PERIOD=3, one with reseed disabled.
module tb_smaesh_arbiter_v2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       seed_v, key_v, data_v, p_busy, p_seeded, k_in_rdy, k_busy, k_last;
  logic       a_in_rdy, a_busy, o_valid, o_ready;
  logic [7:0] tag;

  smaesh_arbiter_v2_if #(.TAG_W(8)) ia ();
  smaesh_arbiter_v2_if #(.TAG_W(8)) ib ();

  assign ia.in_seed_valid = seed_v;   assign ib.in_seed_valid = seed_v;
  assign ia.in_key_valid  = key_v;    assign ib.in_key_valid  = key_v;
  assign ia.in_data_valid = data_v;   assign ib.in_data_valid = data_v;
  assign ia.in_data_tag   = tag;      assign ib.in_data_tag   = tag;
  assign ia.prng_busy     = p_busy;   assign ib.prng_busy     = p_busy;
  assign ia.prng_seeded   = p_seeded; assign ib.prng_seeded   = p_seeded;
  assign ia.KSU_in_ready  = k_in_rdy; assign ib.KSU_in_ready  = k_in_rdy;
  assign ia.KSU_busy      = k_busy;   assign ib.KSU_busy      = k_busy;
  assign ia.KSU_last_key_computation_required = k_last;
  assign ib.KSU_last_key_computation_required = k_last;
  assign ia.aes_in_ready  = a_in_rdy; assign ib.aes_in_ready  = a_in_rdy;
  assign ia.aes_busy      = a_busy;   assign ib.aes_busy      = a_busy;
  assign ia.out_valid     = o_valid;  assign ib.out_valid     = o_valid;
  assign ia.out_ready     = o_ready;  assign ib.out_ready     = o_ready;

  smaesh_arbiter_v2 #(.RESEED_PERIOD(3), .TAG_W(8), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ia.master));
  smaesh_arbiter_v2 #(.RESEED_PERIOD(0), .TAG_W(8), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ib.master));

  logic       dsel;
  logic       s_rdy, k_rdy, d_rdy, rs_p, kv, kf, av, rr;
  logic [7:0] otag;
  assign s_rdy = dsel ? ib.in_seed_ready             : ia.in_seed_ready;
  assign k_rdy = dsel ? ib.in_key_ready              : ia.in_key_ready;
  assign d_rdy = dsel ? ib.in_data_ready             : ia.in_data_ready;
  assign rs_p  = dsel ? ib.prng_start_reseed         : ia.prng_start_reseed;
  assign kv    = dsel ? ib.KSU_valid_in              : ia.KSU_valid_in;
  assign kf    = dsel ? ib.KSU_start_fetch_procedure : ia.KSU_start_fetch_procedure;
  assign av    = dsel ? ib.aes_valid_in              : ia.aes_valid_in;
  assign rr    = dsel ? ib.reseed_required           : ia.reseed_required;
  assign otag  = dsel ? ib.out_tag                   : ia.out_tag;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    seed_v = 0; key_v = 0; data_v = 0; tag = 8'h00; p_busy = 0; p_seeded = 0;
    k_in_rdy = 0; k_busy = 0; k_last = 0; a_in_rdy = 1; a_busy = 0; o_valid = 0; o_ready = 0;
  endtask

  task automatic send(input logic [7:0] t, input logic acc, input string name);
    data_v = 1; tag = t;
    @(negedge clk);
    chk({name, " in_data_ready"}, d_rdy, acc);
    chk({name, " aes_valid_in"}, av, acc);
    if (acc) exp_q.push_back(t);
    tick();
    data_v = 0;
  endtask

  task automatic pop_one(input string name);
    o_valid = 1; o_ready = 1;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: output popped with no expected tag, got %0h", name, otag);
    end else chk(name, otag, exp_q.pop_front());
    tick();
    o_valid = 0; o_ready = 0;
  endtask

  task automatic seed(input string name);
    seed_v = 1; p_busy = 0; p_seeded = 1;
    @(negedge clk);
    chk({name, " seed_ready"}, s_rdy, 1);
    chk({name, " reseed pulse"}, rs_p, 1);
    tick();
    seed_v = 0;
    tick();
  endtask

  task automatic load_key(input string name);
    key_v = 1;
    @(negedge clk);
    chk({name, " fetch pulse"}, kf, 1);
    tick();
    k_in_rdy = 1;
    @(negedge clk);
    chk({name, " key_ready"}, k_rdy, 1);
    tick();
    key_v = 0; k_busy = 1;
    tick();
    k_busy = 0; k_last = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clr_inputs();
    dsel = 0; rst = 1; seed_v = 1;
    @(negedge clk);
    chk("rst seed_ready", s_rdy, 0);
    chk("rst reseed_required", rr, 0);
    chk("rst out_tag", otag, 0);
    @(posedge clk); #1 rst = 0;

    // First seed; PRNG stays busy for one cycle while reseeding.
    @(negedge clk);
    chk("seed_ready after rst", s_rdy, 1);
    chk("reseed pulse", rs_p, 1);
    tick();
    p_busy = 1; data_v = 1; tag = 8'h55;
    @(negedge clk);
    chk("reseed pulse width", rs_p, 0);
    chk("reseeding seed_ready", s_rdy, 0);
    chk("reseeding data_ready", d_rdy, 0);
    tick();
    seed_v = 0; p_busy = 0; p_seeded = 1;
    tick();
    @(negedge clk);
    chk("nokey data_ready", d_rdy, 0);
    chk("nokey aes_valid", av, 0);
    tick();

    // Key load needing the last-round key computation.
    data_v = 0; key_v = 1;
    @(negedge clk);
    chk("fetch pulse", kf, 1);
    chk("key_ready in action cycle", k_rdy, 0);
    tick();
    k_in_rdy = 1;
    @(negedge clk);
    chk("fetch key_ready", k_rdy, 1);
    chk("fetch KSU_valid_in", kv, 1);
    chk("fetch pulse width", kf, 0);
    tick();
    key_v = 0; k_busy = 1;
    tick();
    k_busy = 0; k_last = 1; a_in_rdy = 0;
    tick();
    k_last = 0;
    @(negedge clk);
    chk("last aes_valid held", av, 1);
    chk("last data_ready", d_rdy, 0);
    tick();
    a_in_rdy = 1;
    @(negedge clk);
    chk("last aes_valid handshake", av, 1);
    tick();
    a_busy = 1;
    @(negedge clk);
    chk("last aes_valid dropped", av, 0);
    tick();
    a_busy = 0;
    tick();

    // Reseed period of 3 blocks.
    send(8'h11, 1, "blk1");
    send(8'h12, 1, "blk2");
    send(8'h13, 1, "blk3");
    send(8'h14, 0, "blk4 held");
    chk("reseed_required set", rr, 1);
    pop_one("tag 11");
    pop_one("tag 12");
    pop_one("tag 13");
    @(negedge clk);
    chk("empty out_tag", otag, 0);
    tick();
    data_v = 1; tag = 8'h14; seed_v = 1;
    @(negedge clk);
    chk("ready seed_ready", s_rdy, 1);
    chk("ready reseed pulse", rs_p, 1);
    chk("data during seed", d_rdy, 0);
    tick();
    seed_v = 0; data_v = 0;
    tick();
    @(negedge clk);
    chk("reseed_required cleared", rr, 0);
    tick();
    send(8'h14, 1, "blk4 after reseed");
    pop_one("tag 14");

    // Seed, key and data all valid at once.
    seed_v = 1; key_v = 1; data_v = 1; tag = 8'h77;
    @(negedge clk);
    chk("simul seed_ready", s_rdy, 1);
    chk("simul reseed pulse", rs_p, 1);
    chk("simul fetch pulse", kf, 0);
    chk("simul data_ready", d_rdy, 0);
    chk("simul aes_valid", av, 0);
    tick();
    seed_v = 0; key_v = 0; data_v = 0;
    tick();

    // Reset in the middle of a key fetch.
    key_v = 1;
    tick();
    @(negedge clk);
    chk("pre-rst key_ready", k_rdy, 1);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("mid-rst key_ready", k_rdy, 0);
    chk("mid-rst KSU_valid_in", kv, 0);
    tick();
    rst = 0; key_v = 0; data_v = 1; tag = 8'h99;
    @(negedge clk);
    chk("post-rst data_ready", d_rdy, 0);
    tick();
    data_v = 0;
    seed("post-rst");
    data_v = 1;
    @(negedge clk);
    chk("post-rst nokey data_ready", d_rdy, 0);
    tick();

    // FIFO depth on the instance with reseed disabled.
    clr_inputs();
    dsel = 1; rst = 1;
    tick();
    rst = 0;
    seed("depth");
    load_key("depth");
    send(8'hA1, 1, "depth A1");
    send(8'hA2, 1, "depth A2");
    send(8'hA3, 1, "depth A3");
    send(8'hA4, 1, "depth A4");
    send(8'hA5, 0, "depth A5 stalled");
    chk("no forced reseed", rr, 0);
    pop_one("tag A1");
    pop_one("tag A2");
    pop_one("tag A3");
    pop_one("tag A4");
    @(negedge clk);
    chk("depth empty out_tag", otag, 0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
